// File: rtl/dmem_sram_responder.sv
// Data-side SRAM responder: byte-laned word array behind a fixed-latency,
// in-order response pipeline with a bounded outstanding-request count.
module dmem_sram_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned QDEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    logic [3:0][7:0]    mem [DEPTH];
    logic [CNT_W-1:0]   pending;
    logic [LATENCY-1:0] pipe_valid;
    logic [31:0]        pipe_data [LATENCY];

    logic              accept;
    logic              legal;
    logic [3:0]        exp_mask;
    logic [ADDR_W-1:0] widx;
    logic              unused_addr_hi;

    // Upper address bits are deliberately dropped: the array aliases.
    assign widx           = addr[ADDR_W+1:2];
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    // Only the registered count gates acceptance; no combinational path from req.
    assign addr_ok = !rst && (pending < CNT_W'(QDEPTH));
    assign accept  = req && addr_ok;

    assign data_ok = pipe_valid[LATENCY-1];
    assign rdata   = pipe_data[LATENCY-1];

    // Alignment and byte-enable legality of the presented request
    always_comb begin
        exp_mask = 4'b1111;
        legal    = 1'b1;
        case (size)
            2'd0: exp_mask = 4'b0001 << addr[1:0];
            2'd1: begin
                exp_mask = 4'b0011 << addr[1:0];
                legal    = !addr[0];
            end
            2'd2:    legal = (addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
        // wstrb only matters for writes
        if (wr && (wstrb != exp_mask)) begin
            legal = 1'b0;
        end
    end

    // Lane-masked array write; no reset so contents survive rst
    always_ff @(posedge clk) begin
        if (accept && legal && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[widx][i] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Response shift pipeline; data only moves with a valid so rdata holds between pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            // Array read is pre-write, so a same-edge write is not visible here
            if (accept) begin
                pipe_data[0] <= (legal && !wr) ? mem[widx] : 32'h0;
            end
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    // Outstanding-request count: accept adds, a presented response retires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            case ({accept, data_ok})
                2'b10:   pending <= pending + CNT_W'(1);
                2'b01:   pending <= pending - CNT_W'(1);
                default: pending <= pending;
            endcase
        end
    end

    // Sticky protocol-error flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept && !legal) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Scoreboard bench for dmem_sram_responder: driver pushes expected responses,
// a negedge monitor pops and compares them on every data_ok.
module tb_dmem_sram_responder;

    localparam int unsigned LAT = 2;
    localparam int unsigned QD  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        addr_ok, data_ok, err;
    logic [31:0] rdata;

    // Shared stimulus for the two throughput instances
    logic        b_req, b_wr;
    logic [31:0] b_wdata;
    logic        f_ok, f_dok, f_err, s_ok, s_dok, s_err;
    logic [31:0] f_rdata, s_rdata;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [31:0] exp_q [$];
    int          acc_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_sram_responder #(.ADDR_W(10), .LATENCY(LAT), .QDEPTH(QD)) u_dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .err(err)
    );

    dmem_sram_responder #(.ADDR_W(10), .LATENCY(1), .QDEPTH(2)) u_fast (
        .clk(clk), .rst(rst), .req(b_req), .wr(b_wr), .size(2'd2), .addr(32'h0),
        .wstrb(4'hF), .wdata(b_wdata), .addr_ok(f_ok), .data_ok(f_dok),
        .rdata(f_rdata), .err(f_err)
    );

    dmem_sram_responder #(.ADDR_W(10), .LATENCY(2), .QDEPTH(1)) u_slow (
        .clk(clk), .rst(rst), .req(b_req), .wr(b_wr), .size(2'd2), .addr(32'h0),
        .wstrb(4'hF), .wdata(b_wdata), .addr_ok(s_ok), .data_ok(s_dok),
        .rdata(s_rdata), .err(s_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest expectation and its latency
    logic [31:0] mon_e;
    int          mon_a;
    always @(negedge clk) begin
        if (data_ok === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_data_ok: got rdata %h, expected no response", rdata);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = acc_q.pop_front();
                if (rdata !== mon_e || (cyc - mon_a) != int'(LAT) - 1) begin
                    n_fail++;
                    $display("FAIL response: got rdata %h after %0d cycles, expected %h after %0d",
                             rdata, cyc - mon_a + 1, mon_e, LAT);
                end
            end
        end
    end

    // Present a request from a negedge; returns the cycles spent waiting for addr_ok
    task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [3:0] st, input logic [31:0] d, input logic [31:0] e,
                         output int waited);
        waited = 0;
        req = 1'b1; wr = w; size = sz; addr = a; wstrb = st; wdata = d;
        while (addr_ok !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (addr_ok !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got addr_ok %b, expected 1 within 50 cycles", addr_ok);
        end else begin
            exp_q.push_back(e);
            acc_q.push_back(cyc + 1);
            @(negedge clk);
        end
        req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d outstanding, expected 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int fa, fd, sa, sd;
        logic [31:0] burst_a [6];
        logic [31:0] burst_e [6];

        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wstrb = '0; wdata = '0;
        b_req = 1'b0; b_wr = 1'b0; b_wdata = 32'h600D_F00D;
        repeat (3) @(negedge clk);
        check("reset_addr_ok", {31'b0, addr_ok}, 32'd0);
        check("reset_data_ok", {31'b0, data_ok}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        #1;
        check("release_addr_ok", {31'b0, addr_ok}, 32'd1);
        @(negedge clk);

        // Word write then read; wstrb ignored on reads
        issue(1'b1, 2'd2, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'h0, w);
        issue(1'b0, 2'd2, 32'h10, 4'h5, 32'h0, 32'hDEAD_BEEF, w);
        drain();
        check("err_after_legal", {31'b0, err}, 32'd0);

        // Byte merge and halfword merge
        issue(1'b1, 2'd2, 32'h10, 4'hF, 32'h1122_3344, 32'h0, w);
        issue(1'b1, 2'd0, 32'h13, 4'b1000, 32'hAA00_0000, 32'h0, w);
        issue(1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 32'hAA22_3344, w);
        issue(1'b1, 2'd2, 32'h14, 4'hF, 32'h0, 32'h0, w);
        issue(1'b1, 2'd1, 32'h16, 4'b1100, 32'hBEEF_0000, 32'h0, w);
        issue(1'b0, 2'd2, 32'h14, 4'h0, 32'h0, 32'hBEEF_0000, w);
        drain();

        // Illegal requests answer with zero, leave memory alone, set err
        issue(1'b1, 2'd2, 32'h20, 4'hF, 32'hCAFE_F00D, 32'h0, w);
        issue(1'b1, 2'd2, 32'h24, 4'hF, 32'h7777_7777, 32'h0, w);
        drain();
        check("err_before_illegal", {31'b0, err}, 32'd0);
        issue(1'b1, 2'd1, 32'h21, 4'b0110, 32'h00AB_CD00, 32'h0, w);
        drain();
        check("err_after_misaligned", {31'b0, err}, 32'd1);
        issue(1'b0, 2'd2, 32'h20, 4'h0, 32'h0, 32'hCAFE_F00D, w);
        issue(1'b0, 2'd3, 32'h20, 4'h0, 32'h0, 32'h0, w);
        issue(1'b1, 2'd2, 32'h24, 4'b0111, 32'h1234_5678, 32'h0, w);
        issue(1'b0, 2'd2, 32'h24, 4'h0, 32'h0, 32'h7777_7777, w);
        drain();
        check("err_sticky", {31'b0, err}, 32'd1);

        // Read ahead of a write to the same word sees old data; read after sees new
        issue(1'b1, 2'd2, 32'h30, 4'hF, 32'h0102_0304, 32'h0, w);
        drain();
        issue(1'b0, 2'd2, 32'h30, 4'h0, 32'h0, 32'h0102_0304, w);
        issue(1'b1, 2'd2, 32'h30, 4'hF, 32'h5555_5555, 32'h0, w);
        issue(1'b0, 2'd2, 32'h30, 4'h0, 32'h0, 32'h5555_5555, w);
        drain();

        // Back-to-back reads must never stall
        burst_a = '{32'h10, 32'h14, 32'h20, 32'h30, 32'h24, 32'h10};
        burst_e = '{32'hAA22_3344, 32'hBEEF_0000, 32'hCAFE_F00D, 32'h5555_5555,
                    32'h7777_7777, 32'hAA22_3344};
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, 2'd2, burst_a[i], 4'h0, 32'h0, burst_e[i], w);
            check("burst_no_stall", 32'(w), 32'd0);
        end
        drain();

        // Reset with two reads in flight drops both responses
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h10; wstrb = 4'h0;
        @(posedge clk);
        @(negedge clk);
        addr = 32'h14;
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 1'b0;
        @(negedge clk);
        check("midrst_data_ok", {31'b0, data_ok}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_addr_ok", {31'b0, addr_ok}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_addr_ok", {31'b0, addr_ok}, 32'd1);
        repeat (4) @(negedge clk);
        check("post_rst_err", {31'b0, err}, 32'd0);
        issue(1'b0, 2'd2, 32'h10, 4'h0, 32'h0, 32'hAA22_3344, w);
        check("post_rst_wait0", 32'(w), 32'd0);
        issue(1'b0, 2'd2, 32'h20, 4'h0, 32'h0, 32'hCAFE_F00D, w);
        check("post_rst_wait1", 32'(w), 32'd0);
        issue(1'b0, 2'd2, 32'h30, 4'h0, 32'h0, 32'h5555_5555, w);
        check("post_rst_wait2", 32'(w), 32'd0);
        drain();

        // Upper address bits alias onto the same word
        issue(1'b1, 2'd2, 32'h0000_1010, 4'hF, 32'h0BAD_CAFE, 32'h0, w);
        issue(1'b0, 2'd2, 32'hFFFF_F010, 4'h0, 32'h0, 32'h0BAD_CAFE, w);
        drain();

        // Throughput of LATENCY=1/QDEPTH=2 and LATENCY=2/QDEPTH=1 with req held high
        b_req = 1'b1; b_wr = 1'b1;
        @(negedge clk);
        b_req = 1'b0;
        repeat (4) @(negedge clk);
        b_wr = 1'b0; b_req = 1'b1;
        fa = 0; fd = 0; sa = 0; sd = 0;
        for (int i = 0; i < 9; i++) begin
            fa += int'(f_ok);
            fd += int'(f_dok);
            sa += int'(s_ok);
            sd += int'(s_dok);
            @(negedge clk);
        end
        b_req = 1'b0;
        repeat (4) @(negedge clk);
        check("fast_addr_ok_cycles", 32'(fa), 32'd9);
        check("fast_data_ok_cycles", 32'(fd), 32'd8);
        check("slow_addr_ok_cycles", 32'(sa), 32'd3);
        check("slow_data_ok_cycles", 32'(sd), 32'd3);
        check("fast_rdata", f_rdata, 32'h600D_F00D);
        check("slow_rdata", s_rdata, 32'h600D_F00D);
        check("fast_err", {31'b0, f_err}, 32'd0);
        check("slow_err", {31'b0, s_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
